n64_controller_responder: RTL and testbench

//  Device end of the N64 one-wire protocol: emulates a standard controller on an open-collector pin.

---
 rtl/n64_controller_responder_if.sv | 13 +
 rtl/n64_controller_responder.sv | 159 +++++++++++++++
 tb/tb_n64_controller_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/n64_controller_responder_if.sv
// n64_controller_responder_if: fabric-side control and status signals of the N64 controller responder.
interface n64_controller_responder_if;
    logic        enable;
    logic [31:0] button_data;
    logic        busy;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        rx_error;
    logic        reset_pulse;
    logic        data_out;
    modport slave (input enable, button_data, output busy, cmd_valid, cmd_byte, rx_error, reset_pulse, data_out);
    modport master (output enable, button_data, input busy, cmd_valid, cmd_byte, rx_error, reset_pulse, data_out);
endinterface

// File: rtl/n64_controller_responder.sv
// n64_controller_responder: N64 controller emulator on an open-collector one-wire pin.
// Defining N64_RESP_RESET_CMD_EN makes 0xFF a known command (reset_pulse plus status reply).
module n64_controller_responder #(
    parameter int          CLKS_PER_US   = 100,
    parameter int          TURNAROUND_US = 2,
    parameter int          TIMEOUT_US    = 8,
    parameter logic [23:0] STATUS_WORD   = 24'h050002
) (
    input  logic clk,
    input  logic reset_n,
    inout  wire  fab_pin,
    n64_controller_responder_if.slave bus
);
    localparam int T  = CLKS_PER_US;
    localparam int TW = $clog2(TIMEOUT_US * T + 1);
    localparam logic [TW-1:0] TO     = TW'(TIMEOUT_US * T);
    localparam logic [TW-1:0] T2     = TW'(2 * T);
    localparam logic [TW-1:0] T1_END = TW'(T - 1);
    localparam logic [TW-1:0] T2_END = TW'(2 * T - 1);
    localparam logic [TW-1:0] T3_END = TW'(3 * T - 1);
    localparam logic [TW-1:0] TA_END = TW'(TURNAROUND_US * T - 1);

    typedef enum logic [2:0] {IDLE, RX_BIT, RX_STOP, TURNAROUND, TX_LOW, TX_HIGH, TX_STOP} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_q, rx_prev_q;
    logic [TW-1:0]   timer_q, timer_d, hi_q, hi_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      cmd_q, cmd_d, cmd_byte_q, cmd_byte_d;
    logic [31:0]     sh_q, sh_d;
    logic            status_q, status_d;
    logic            cmd_valid_q, cmd_valid_d, rx_error_q, rx_error_d, rst_pulse_q, rst_pulse_d;
    logic            fell, rose, known, rst_cmd, drive_low, last_bit;
    logic [TW-1:0]   low_end, high_end;

    assign fell      = rx_prev_q & ~rx_q;
    assign rose      = ~rx_prev_q & rx_q;
`ifdef N64_RESP_RESET_CMD_EN
    assign rst_cmd   = cmd_q == 8'hFF;
`else
    assign rst_cmd   = 1'b0;
`endif
    assign known     = cmd_q == 8'h00 || cmd_q == 8'h01 || rst_cmd;
    assign low_end   = sh_q[31] ? T1_END : T3_END;
    assign high_end  = sh_q[31] ? T3_END : T1_END;
    assign last_bit  = bit_cnt_q == (status_q ? 6'd23 : 6'd31);
    assign drive_low = state_q == TX_LOW || state_q == TX_STOP;

    assign fab_pin         = drive_low ? 1'b0 : 1'bz;
    assign bus.data_out    = ~drive_low;
    assign bus.busy        = state_q != IDLE;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_byte    = cmd_byte_q;
    assign bus.rx_error    = rx_error_q;
    assign bus.reset_pulse = rst_pulse_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b0;
            rx_q        <= 1'b0;
            rx_prev_q   <= 1'b0;
            timer_q     <= '0;
            hi_q        <= '0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            cmd_byte_q  <= '0;
            sh_q        <= '0;
            status_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            rx_error_q  <= 1'b0;
            rst_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= fab_pin;
            rx_q        <= rx_meta_q;
            rx_prev_q   <= rx_q;
            timer_q     <= timer_d;
            hi_q        <= hi_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            cmd_byte_q  <= cmd_byte_d;
            sh_q        <= sh_d;
            status_q    <= status_d;
            cmd_valid_q <= cmd_valid_d;
            rx_error_q  <= rx_error_d;
            rst_pulse_q <= rst_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q == TO ? timer_q : timer_q + 1'b1;
        hi_d        = (state_q == RX_BIT && rx_q) ? (hi_q == TO ? hi_q : hi_q + 1'b1) : '0;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        cmd_byte_d  = cmd_byte_q;
        sh_d        = sh_q;
        status_d    = status_q;
        cmd_valid_d = 1'b0;
        rx_error_d  = 1'b0;
        rst_pulse_d = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: if (fell) begin
                    state_d   = RX_BIT;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                end
                RX_BIT: if (fell && timer_q <= T2) begin
                    rx_error_d = 1'b1;
                    state_d    = IDLE;
                end else if (fell) begin
                    timer_d = '0;
                    state_d = bit_cnt_q == 6'd8 ? RX_STOP : RX_BIT;
                end else if (rx_q && hi_q == TO) begin
                    rx_error_d = 1'b1;
                    state_d    = IDLE;
                end else if (timer_q == T2 && bit_cnt_q != 6'd8) begin
                    cmd_d     = {cmd_q[6:0], rx_q};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
                RX_STOP: if (rose) begin
                    cmd_valid_d = 1'b1;
                    cmd_byte_d  = cmd_q;
                    rst_pulse_d = rst_cmd;
                    state_d     = known ? TURNAROUND : IDLE;
                    timer_d     = '0;
                end else if (timer_q >= T2) begin
                    rx_error_d = 1'b1;
                    state_d    = IDLE;
                end
                // The reply word is captured here so later button_data changes cannot corrupt it.
                TURNAROUND: if (timer_q == TA_END) begin
                    sh_d      = cmd_q == 8'h01 ? bus.button_data : {STATUS_WORD, 8'h00};
                    status_d  = cmd_q != 8'h01;
                    bit_cnt_d = '0;
                    state_d   = TX_LOW;
                    timer_d   = '0;
                end
                TX_LOW: if (timer_q == low_end) begin
                    state_d = TX_HIGH;
                    timer_d = '0;
                end
                TX_HIGH: if (timer_q == high_end) begin
                    timer_d   = '0;
                    state_d   = last_bit ? TX_STOP : TX_LOW;
                    sh_d      = last_bit ? sh_q : {sh_q[30:0], 1'b0};
                    bit_cnt_d = last_bit ? bit_cnt_q : bit_cnt_q + 6'd1;
                end
                TX_STOP: if (timer_q == T2_END) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_n64_controller_responder.sv
// tb_n64_controller_responder: host-side driver plus a line-level reply decoder that checks
// decoded replies, command pulses and timing against expectations derived from the command.
module tb_n64_controller_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_low = 1'b0;
    wire         line;
    int          checks = 0, passed = 0, cyc = 0;
    int          rel_cyc = 0, valids = 0, errs = 0, rsts = 0, bits = 0, low_len = 0, last_bits = 0;
    int          exp_nbits = 0;
    logic [31:0] word = '0, last_word = '0, exp_word = '0;
    logic [7:0]  exp_cmd = '0;
    logic        pending = 1'b0, exp_err = 1'b0, mon_on = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pullup (line);
    assign line = host_low ? 1'b0 : 1'bz;

    n64_controller_responder_if bus ();
    n64_controller_responder dut (.clk(clk), .reset_n(reset_n), .fab_pin(line), .bus(bus));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic exp_rst();
`ifdef N64_RESP_RESET_CMD_EN
        return exp_cmd == 8'hFF;
`else
        return 1'b0;
`endif
    endfunction

    // Reply decoder: low of 1T = data 1, 3T = data 0, 2T = stop bit closing the reply.
    always @(negedge clk) begin
        if (bus.cmd_valid) begin
            valids++;
            check("cmd_byte", 32'(bus.cmd_byte), 32'(exp_cmd));
            check("reset_pulse", 32'(bus.reset_pulse), 32'(exp_rst()));
            if (bus.reset_pulse) rsts++;
        end else if (bus.reset_pulse !== 1'b0) check("reset_pulse_stray", 32'(bus.reset_pulse), 32'd0);
        if (bus.rx_error) begin
            errs++;
            check("rx_error_timing", 32'(exp_err && cyc - rel_cyc >= 795 && cyc - rel_cyc <= 815), 32'd1);
        end
        if (!mon_on) begin
            bits = 0;
            word = '0;
            low_len = 0;
        end else if (!host_low && line === 1'b0) begin
            if (low_len == 0 && bits == 0) begin
                check("reply_allowed", 32'(pending), 32'd1);
                check("turnaround_gap", 32'(cyc - rel_cyc >= 195 && cyc - rel_cyc <= 215), 32'd1);
            end
            low_len++;
        end else if (!host_low && low_len != 0) begin
            if (low_len >= 150 && low_len < 250) begin
                check("stop_low", 32'(low_len), 32'd200);
                check("reply_bits", 32'(bits), 32'(exp_nbits));
                check("reply_word", word, exp_word);
                last_word = word;
                last_bits = bits;
                pending = 1'b0;
                bits = 0;
                word = '0;
            end else begin
                check("bit_low", 32'(low_len == 100 || low_len == 300), 32'd1);
                word = {word[30:0], low_len < 150};
                bits++;
            end
            low_len = 0;
        end
    end

    task automatic hold(input logic low, input int n);
        if (!low && host_low) rel_cyc = cyc;
        host_low = low;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, b[7-i] ? 100 : 300);
            hold(1'b0, b[7-i] ? 300 : 100);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_bits(b, 8);
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        hold(1'b1, 100);
        hold(1'b0, 1);
    endtask

    task automatic host_cmd(input logic [7:0] b, input logic reply, input logic [31:0] w, input int n);
        int v0;
        hold(1'b0, 50);
        exp_cmd = b;
        exp_word = w;
        exp_nbits = n;
        pending = reply;
        v0 = valids;
        send_cmd(b);
        for (int i = 0; i < 16000 && (pending || bus.busy); i++) @(posedge clk);
        #1;
        check("cmd_valid_count", 32'(valids - v0), 32'd1);
        check("reply_done", 32'(pending), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("line_released", 32'(line), 32'd1);
    endtask

    initial begin
        int v0, e0, r0;
        bus.enable = 1'b1;
        bus.button_data = '0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_cmd_byte", 32'(bus.cmd_byte), 32'd0);
        check("rst_rx_error", 32'(bus.rx_error), 32'd0);
        check("rst_reset_pulse", 32'(bus.reset_pulse), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd1);
        check("rst_line", 32'(line), 32'd1);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        bus.button_data = 32'h8001_40FF;
        host_cmd(8'h01, 1'b1, 32'h8001_40FF, 32);
        check("t1_word", last_word, 32'h8001_40FF);
        check("t1_cmd_byte", 32'(bus.cmd_byte), 32'h01);

        host_cmd(8'h00, 1'b1, 32'h0005_0002, 24);
        check("t2_word", last_word, 32'h0005_0002);
        check("t2_bits", 32'(last_bits), 32'd24);

        r0 = rsts;
`ifdef N64_RESP_RESET_CMD_EN
        host_cmd(8'hFF, 1'b1, 32'h0005_0002, 24);
        check("t3_reset_pulses", 32'(rsts - r0), 32'd1);
`else
        host_cmd(8'hFF, 1'b0, 32'h0, 0);
        check("t3_reset_pulses", 32'(rsts - r0), 32'd0);
`endif

        host_cmd(8'h3C, 1'b0, 32'h0, 0);
        check("t4_cmd_byte", 32'(bus.cmd_byte), 32'h3C);

        hold(1'b0, 50);
        v0 = valids;
        e0 = errs;
        exp_err = 1'b1;
        send_bits(8'hB0, 5);
        for (int i = 0; i < 1200 && errs == e0; i++) @(posedge clk);
        #1;
        check("t5_rx_errors", 32'(errs - e0), 32'd1);
        check("t5_no_cmd_valid", 32'(valids - v0), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        exp_err = 1'b0;
        bus.button_data = 32'h1234_5678;
        host_cmd(8'h01, 1'b1, 32'h1234_5678, 32);
        check("t5_recover_word", last_word, 32'h1234_5678);

        bus.button_data = 32'hA5C3_0F96;
        fork
            host_cmd(8'h01, 1'b1, 32'hA5C3_0F96, 32);
            begin
                for (int i = 0; i < 20000 && bits != 10; i++) @(posedge clk);
                check("t6_bit10_reached", 32'(bits), 32'd10);
                bus.button_data = 32'h0000_0000;
            end
        join
        check("t6_latched_word", last_word, 32'hA5C3_0F96);

        mon_on = 1'b0;
        bus.button_data = 32'hFFFF_FFFF;
        hold(1'b0, 50);
        exp_cmd = 8'h01;
        send_cmd(8'h01);
        for (int i = 0; i < 2000 && line !== 1'b0; i++) @(negedge clk);
        check("t6_reply_started", 32'(line), 32'd0);
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_abort_pin_z", 32'(line), 32'd1);
        check("t6_abort_busy", 32'(bus.busy), 32'd0);
        check("t6_abort_data_out", 32'(bus.data_out), 32'd1);
        repeat (500) @(negedge clk);
        check("t6_abort_stays_z", 32'(line), 32'd1);
        bus.enable = 1'b1;

        hold(1'b0, 50);
        exp_cmd = 8'h00;
        send_cmd(8'h00);
        for (int i = 0; i < 2000 && line !== 1'b0; i++) @(negedge clk);
        check("t7_reply_started", 32'(line), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_async_release", 32'(line), 32'd1);
        check("t7_async_busy", 32'(bus.busy), 32'd0);
        check("t7_async_cmd_byte", 32'(bus.cmd_byte), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t7_line_idle", 32'(line), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
